// File: rtl/arm_pkg.sv
// Shared ARM-subset definitions used by the ID control unit and the EXE stage.
//   exe_cmd_e : 4-bit ALU opcodes driven on EXE_CMD
//   shift_e   : register-operand shift types taken from Shift_operand[6:5]
//   status_t  : {N,Z,C,V} status word layout
//   ror32     : 32-bit rotate right helper
package arm_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } status_t;

  // Shifting a 32-bit value left by 32 yields 0, so amt == 0 returns x.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    return (x >> amt) | (x << (6'd32 - {1'b0, amt}));
  endfunction

endpackage

// File: rtl/val2_gen.sv
// Second-operand generator for the EXE stage.
//   imm           : 1 = rotated 8-bit immediate
//   mem_en        : load/store, use the raw 12-bit offset
//   shift_operand : 12-bit operand field from the instruction
//   val_rm        : register operand Rm
//   val2          : resulting second ALU operand
module val2_gen
  import arm_pkg::*;
(
  input  logic        imm,
  input  logic        mem_en,
  input  logic [11:0] shift_operand,
  input  logic [31:0] val_rm,
  output logic [31:0] val2
);

  logic [4:0] shift_amt;
  shift_e     shift_type;

  assign shift_amt  = shift_operand[11:7];
  assign shift_type = shift_e'(shift_operand[6:5]);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    val2 = val_rm;
    if (imm) begin
      // Rotate amount is encoded in units of two bit positions.
      val2 = ror32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else if (mem_en) begin
      val2 = {20'b0, shift_operand};
    end else begin
      // A zero shift amount naturally passes val_rm unchanged for all four types.
      case (shift_type)
        SHIFT_LSL: val2 = val_rm << shift_amt;
        SHIFT_LSR: val2 = val_rm >> shift_amt;
        SHIFT_ASR: val2 = 32'($signed(val_rm) >>> shift_amt);
        SHIFT_ROR: val2 = ror32(val_rm, shift_amt);
        default:   val2 = val_rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM-subset pipeline: ALU, status register and
// EXE/MEM pipeline register.
//   clk, rst (sync, active-low), freeze (memory-stage stall)
//   *_IN            : control and operands from the ID/EXE register
//   Branch_Taken    : combinational copy of B_IN
//   Branch_Addr     : combinational PC_IN + sign-extended offset * 4
//   SR              : registered {N,Z,C,V}
//   WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest : EXE/MEM register
module exe_stage
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic        B_IN,
  input  logic        S_IN,
  input  logic [3:0]  EXE_CMD_IN,
  input  logic [31:0] PC_IN,
  input  logic [31:0] Val_Rn_IN,
  input  logic [31:0] Val_Rm_IN,
  input  logic        imm_IN,
  input  logic [11:0] Shift_operand_IN,
  input  logic [23:0] Signed_imm_24_IN,
  input  logic [3:0]  Dest_IN,
  output logic        Branch_Taken,
  output logic [31:0] Branch_Addr,
  output logic [3:0]  SR,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic [31:0] ALU_Res,
  output logic [31:0] Val_Rm,
  output logic [3:0]  Dest
);

  exe_cmd_e    cmd;
  status_t     sr_q;
  status_t     flags_d;
  logic [31:0] val2;
  logic [31:0] addend;
  logic        carry_in;
  logic [32:0] sum;
  logic [31:0] alu_res;
  logic        is_arith;

  assign cmd = exe_cmd_e'(EXE_CMD_IN);

  // Branches resolve here but never flush this stage's own register.
  assign Branch_Taken = B_IN;
  assign Branch_Addr  = PC_IN + {{6{Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};

  val2_gen u_val2_gen (
    .imm           (imm_IN),
    .mem_en        (MEM_R_EN_IN | MEM_W_EN_IN),
    .shift_operand (Shift_operand_IN),
    .val_rm        (Val_Rm_IN),
    .val2          (val2)
  );

  // One shared 33-bit adder: subtraction is Rn + ~Val2 + cin, so the carry
  // out is directly NOT-borrow. ADC/SBC take C from the registered SR.
  always_comb begin
    addend   = val2;
    carry_in = 1'b0;
    case (cmd)
      CMD_ADC: carry_in = sr_q.c;
      CMD_SUB: begin
        addend   = ~val2;
        carry_in = 1'b1;
      end
      CMD_SBC: begin
        addend   = ~val2;
        carry_in = sr_q.c;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, Val_Rn_IN} + {1'b0, addend} + {32'b0, carry_in};

  always_comb begin
    alu_res  = '0;
    is_arith = 1'b0;
    case (cmd)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        alu_res  = sum[31:0];
        is_arith = 1'b1;
      end
      CMD_AND: alu_res = Val_Rn_IN & val2;
      CMD_ORR: alu_res = Val_Rn_IN | val2;
      CMD_EOR: alu_res = Val_Rn_IN ^ val2;
      default: alu_res = '0;
    endcase
  end

  // Logic ops and moves keep C and V from the current SR.
  always_comb begin
    flags_d   = sr_q;
    flags_d.n = alu_res[31];
    flags_d.z = (alu_res == 32'b0);
    if (is_arith) begin
      flags_d.c = sum[32];
      flags_d.v = (Val_Rn_IN[31] == addend[31]) && (sum[31] != Val_Rn_IN[31]);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q     <= '0;
      WB_EN    <= 1'b0;
      MEM_R_EN <= 1'b0;
      MEM_W_EN <= 1'b0;
      ALU_Res  <= '0;
      Val_Rm   <= '0;
      Dest     <= '0;
    end else if (!freeze) begin
      WB_EN    <= WB_EN_IN;
      MEM_R_EN <= MEM_R_EN_IN;
      MEM_W_EN <= MEM_W_EN_IN;
      ALU_Res  <= alu_res;
      Val_Rm   <= Val_Rm_IN;
      Dest     <= Dest_IN;
      if (S_IN) sr_q <= flags_d;
    end
  end

  assign SR = sr_q;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN;
  logic [3:0]  EXE_CMD_IN, Dest_IN;
  logic [31:0] PC_IN, Val_Rn_IN, Val_Rm_IN;
  logic [11:0] Shift_operand_IN;
  logic [23:0] Signed_imm_24_IN;
  logic        Branch_Taken, WB_EN, MEM_R_EN, MEM_W_EN;
  logic [31:0] Branch_Addr, ALU_Res, Val_Rm;
  logic [3:0]  SR, Dest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .B_IN(B_IN), .S_IN(S_IN), .EXE_CMD_IN(EXE_CMD_IN), .PC_IN(PC_IN),
    .Val_Rn_IN(Val_Rn_IN), .Val_Rm_IN(Val_Rm_IN), .imm_IN(imm_IN),
    .Shift_operand_IN(Shift_operand_IN), .Signed_imm_24_IN(Signed_imm_24_IN),
    .Dest_IN(Dest_IN), .Branch_Taken(Branch_Taken), .Branch_Addr(Branch_Addr),
    .SR(SR), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest)
  );

  typedef struct {
    logic        rst, frz, wb, mr, mw, b, s, imm;
    logic [3:0]  cmd, dest;
    logic [31:0] pc, rn, rm;
    logic [11:0] so;
    logic [23:0] off;
  } stim_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] m_val2(input logic imm, input logic mem,
                                         input logic [11:0] so, input logic [31:0] rm);
    longint unsigned x, r;
    longint signed   sv, p;
    int amt;
    if (imm) begin
      x = longint'(so[7:0]);
      r = 2 * longint'(so[11:8]);
      return 32'(((x >> r) | (x << (32 - r))) & 64'hFFFF_FFFF);
    end
    if (mem) return {20'b0, so};
    amt = int'(so[11:7]);
    p   = longint'(1) << amt;
    case (so[6:5])
      2'b00: return 32'((longint'(rm) * p) & 64'hFFFF_FFFF);
      2'b01: return 32'(longint'(rm) / p);
      2'b10: begin
        sv = longint'($signed(rm));
        if (sv >= 0) return 32'(sv / p);
        return 32'(-((-sv + p - 1) / p));  // floor division for negatives
      end
      default: begin
        x = {32'b0, rm};
        x = (x << 32) | x;
        return 32'(x >> amt);
      end
    endcase
  endfunction

  function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] rn,
                                input logic [31:0] v2, input logic c_in,
                                output logic [31:0] res, output logic c,
                                output logic v, output logic arith);
    longint signed   sa, sb, sr;
    longint unsigned ua, ub, ur;
    sa = longint'($signed(rn)); sb = longint'($signed(v2));
    ua = longint'(rn);          ub = longint'(v2);
    c = 1'b0; v = 1'b0; arith = 1'b0; sr = 0; ur = 0;
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2, 4'd3: begin
        ur = ua + ub + ((cmd == 4'd3) ? longint'(c_in) : 0);
        sr = sa + sb + ((cmd == 4'd3) ? longint'(c_in) : 0);
        res = 32'(ur & 64'hFFFF_FFFF);
        c = (ur >> 32) != 0;
        arith = 1'b1;
      end
      4'd4, 4'd5: begin
        ub = ub + ((cmd == 4'd5) ? longint'(!c_in) : 0);
        sb = sb + ((cmd == 4'd5) ? longint'(!c_in) : 0);
        sr = sa - sb;
        res = 32'((ua - ub) & 64'hFFFF_FFFF);
        c = (ua >= ub);
        arith = 1'b1;
      end
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      default: res = 32'b0;
    endcase
    if (arith) v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  logic        m_valid = 1'b0;
  logic [3:0]  m_sr, m_dest;
  logic        m_wb, m_mr, m_mw;
  logic [31:0] m_res, m_rm;

  always @(posedge clk) begin
    logic [31:0] v2, res;
    logic        c, v, arith;
    v2 = m_val2(imm_IN, MEM_R_EN_IN | MEM_W_EN_IN, Shift_operand_IN, Val_Rm_IN);
    m_alu(EXE_CMD_IN, Val_Rn_IN, v2, m_sr[1], res, c, v, arith);
    if (!rst) begin
      m_sr = 4'b0; m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
      m_res = 32'b0; m_rm = 32'b0; m_dest = 4'b0;
    end else if (!freeze) begin
      m_wb = WB_EN_IN; m_mr = MEM_R_EN_IN; m_mw = MEM_W_EN_IN;
      m_res = res; m_rm = Val_Rm_IN; m_dest = Dest_IN;
      if (S_IN) m_sr = {res[31], res == 32'b0, arith ? c : m_sr[1], arith ? v : m_sr[0]};
    end
    m_valid = 1'b1;
  end

  // Compare process: registered outputs against the model, combinational
  // branch outputs against the current inputs.
  always @(negedge clk) begin
    longint signed ba;
    if (m_valid) begin
      check("SR", 32'(SR), 32'(m_sr));
      check("WB_EN", 32'(WB_EN), 32'(m_wb));
      check("MEM_R_EN", 32'(MEM_R_EN), 32'(m_mr));
      check("MEM_W_EN", 32'(MEM_W_EN), 32'(m_mw));
      check("ALU_Res", ALU_Res, m_res);
      check("Val_Rm", Val_Rm, m_rm);
      check("Dest", 32'(Dest), 32'(m_dest));
      ba = longint'(PC_IN) + 4 * longint'($signed(Signed_imm_24_IN));
      check("Branch_Addr", Branch_Addr, 32'(ba & 64'hFFFF_FFFF));
      check("Branch_Taken", 32'(Branch_Taken), 32'(B_IN));
    end
  end

  // ---------------- stimulus ----------------
  function automatic stim_t base();
    stim_t s;
    s.rst = 1'b1; s.frz = 1'b0; s.wb = 1'b1; s.mr = 1'b0; s.mw = 1'b0;
    s.b = 1'b0; s.s = 1'b0; s.imm = 1'b0; s.cmd = 4'd0; s.dest = 4'd0;
    s.pc = 32'b0; s.rn = 32'b0; s.rm = 32'b0; s.so = 12'b0; s.off = 24'b0;
    return s;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; freeze = s.frz; WB_EN_IN = s.wb; MEM_R_EN_IN = s.mr;
    MEM_W_EN_IN = s.mw; B_IN = s.b; S_IN = s.s; imm_IN = s.imm;
    EXE_CMD_IN = s.cmd; Dest_IN = s.dest; PC_IN = s.pc; Val_Rn_IN = s.rn;
    Val_Rm_IN = s.rm; Shift_operand_IN = s.so; Signed_imm_24_IN = s.off;
  endtask

  // Drive one instruction, let it cross an edge, return at the following negedge.
  task automatic step(input stim_t s);
    #1;
    apply(s);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    stim_t s;
    apply(base());
    rst = 1'b0;

    // Reset overrides freeze and S_IN.
    s = base(); s.rst = 1'b0; s.frz = 1'b1; s.s = 1'b1; s.cmd = 4'd2; s.rn = 32'h1234_5678;
    s.so = 12'h0FF; s.imm = 1'b1; s.dest = 4'hF;
    step(s); step(s);
    check("reset SR", 32'(SR), 32'h0);
    check("reset ALU_Res", ALU_Res, 32'h0);
    check("reset WB_EN", 32'(WB_EN), 32'h0);
    check("reset Dest", 32'(Dest), 32'h0);

    // ADD overflow: 0x7FFFFFFF + 1.
    s = base(); s.cmd = 4'd2; s.rn = 32'h7FFF_FFFF; s.imm = 1'b1; s.so = 12'h001; s.s = 1'b1;
    step(s);
    check("add ALU_Res", ALU_Res, 32'h8000_0000);
    check("add SR", 32'(SR), 32'b1001);

    // CMP-style SUB 5-5 without writeback.
    s = base(); s.cmd = 4'd4; s.rn = 32'd5; s.imm = 1'b1; s.so = 12'h005; s.s = 1'b1; s.wb = 1'b0;
    step(s);
    check("sub SR", 32'(SR), 32'b0110);
    check("sub WB_EN", 32'(WB_EN), 32'h0);

    // MOV with rotated immediate.
    s = base(); s.cmd = 4'd1; s.imm = 1'b1; s.so = 12'h4FF;
    step(s);
    check("ror imm ALU_Res", ALU_Res, 32'hFF00_0000);
    check("no-S SR hold", 32'(SR), 32'b0110);

    // MOV of Rm ASR #4, sets N and keeps C.
    s = base(); s.cmd = 4'd1; s.rm = 32'h8000_0000; s.so = {5'd4, 2'b10, 5'd0}; s.s = 1'b1; s.dest = 4'hA;
    step(s);
    check("asr ALU_Res", ALU_Res, 32'hF800_0000);
    check("asr SR", 32'(SR), 32'b1010);

    // Freeze for three cycles with changing inputs and S=1.
    for (int i = 0; i < 3; i++) begin
      s = base(); s.frz = 1'b1; s.s = 1'b1; s.cmd = 4'd2; s.rn = $urandom; s.rm = $urandom;
      s.so = 12'($urandom); s.dest = 4'($urandom); s.wb = 1'b0;
      step(s);
      check("freeze ALU_Res", ALU_Res, 32'hF800_0000);
      check("freeze SR", 32'(SR), 32'b1010);
      check("freeze Dest", 32'(Dest), 32'hA);
      check("freeze Val_Rm", Val_Rm, 32'h8000_0000);
    end
    s = base(); s.cmd = 4'd1; s.imm = 1'b1; s.so = 12'h0AB; s.s = 1'b1; s.dest = 4'h3;
    step(s);
    check("resume ALU_Res", ALU_Res, 32'h0000_00AB);
    check("resume SR", 32'(SR), 32'b0010);
    check("resume Dest", 32'(Dest), 32'h3);

    // ADC uses the registered carry, not the one produced this cycle.
    s = base(); s.cmd = 4'd4; s.rn = 32'd5; s.imm = 1'b1; s.so = 12'h005; s.s = 1'b1;
    step(s);
    s = base(); s.cmd = 4'd3; s.rn = 32'd1; s.imm = 1'b1; s.so = 12'h001; s.s = 1'b1;
    step(s);
    check("adc c=1 ALU_Res", ALU_Res, 32'd3);
    check("adc SR", 32'(SR), 32'b0000);
    step(s);
    check("adc c=0 ALU_Res", ALU_Res, 32'd2);

    // Branch target, same cycle.
    s = base(); s.pc = 32'h100; s.off = 24'hFFFFFE; s.b = 1'b1;
    #1; apply(s); #1;
    check("branch taken", 32'(Branch_Taken), 32'h1);
    check("branch addr", Branch_Addr, 32'h0000_00F8);
    @(negedge clk);

    // Mid-stream reset discards the in-flight ADD and its flags.
    s = base(); s.rst = 1'b0; s.cmd = 4'd2; s.rn = 32'hFFFF_FFFF; s.imm = 1'b1; s.so = 12'h001; s.s = 1'b1;
    step(s);
    check("midreset ALU_Res", ALU_Res, 32'h0);
    check("midreset SR", 32'(SR), 32'h0);

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 600; i++) begin
      s = base();
      s.rst  = ($urandom_range(0, 49) != 0);
      s.frz  = ($urandom_range(0, 5) == 0);
      s.wb   = 1'($urandom); s.b = 1'($urandom); s.s = 1'($urandom);
      s.imm  = 1'($urandom);
      s.mr   = ($urandom_range(0, 7) == 0);
      s.mw   = ($urandom_range(0, 7) == 0);
      s.cmd  = 4'($urandom_range(0, 10));
      s.dest = 4'($urandom);
      s.pc   = rand_word(); s.rn = rand_word(); s.rm = rand_word();
      s.so   = 12'($urandom); s.off = 24'($urandom);
      step(s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
